// File: rtl/prom_pattern_sequencer_pkg.sv
// Shared constants and state type for the PROM pattern sequencer.
// Word layout: bits [31:0] pattern, bits [35:32] duration code.
package prom_seq_pkg;

  localparam int DEF_ADDR_W     = 7;
  localparam int DEF_DATA_W     = 36;
  localparam int DEF_PRESCALE_W = 24;

  localparam int DUR_MSB = 35;
  localparam int DUR_LSB = 32;
  localparam int DUR_W   = DUR_MSB - DUR_LSB + 1;
  localparam int PAT_W   = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LATCH,
    HOLD
  } seq_state_t;

endpackage

// File: rtl/prom_pattern_sequencer_timer.sv
// Hold-time timer: a tick prescaler feeding a repeat counter.
// Expires on the last tick of the last repeat of the current entry.
module prom_seq_timer
  import prom_seq_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [DUR_W-1:0]      dur,
  output logic                  expire
);

  logic [PRESCALE_W-1:0] tick_q, tick_d;
  logic [DUR_W-1:0]      rep_q, rep_d;
  logic [DUR_W-1:0]      dur_q, dur_d;

  always_comb begin
    tick_d = tick_q;
    rep_d  = rep_q;
    dur_d  = dur_q;
    if (load) begin
      tick_d = '0;
      rep_d  = '0;
      dur_d  = dur;
    end else if (en) begin
      if (tick_q == prescale) begin
        tick_d = '0;
        rep_d  = rep_q + DUR_W'(1);
      end else begin
        tick_d = tick_q + PRESCALE_W'(1);
      end
    end
  end

  assign expire = en && (tick_q == prescale) && (rep_q == dur_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
      rep_q  <= '0;
      dur_q  <= '0;
    end else begin
      tick_q <= tick_d;
      rep_q  <= rep_d;
      dur_q  <= dur_d;
    end
  end

endmodule

// File: rtl/prom_pattern_sequencer.sv
// Walks a programmable PROM address window and drives four LED banks.
// Optional macro PROM_SEQ_BLANK_EN blanks the banks while IDLE.
module prom_pattern_sequencer
  import prom_seq_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [ADDR_W-1:0]     first_addr,
  input  logic [ADDR_W-1:0]     last_addr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_dout,
  output logic [7:0]            bank0,
  output logic [7:0]            bank1,
  output logic [7:0]            bank2,
  output logic [7:0]            bank3,
  output logic                  busy,
  output logic                  done
);

  seq_state_t            state_q, state_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [PAT_W-1:0]      pattern_q, pattern_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADDR_W-1:0]     first_q, first_d;
  logic [ADDR_W-1:0]     last_q, last_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  loop_q, loop_d;
  logic                  expire;
  logic [PAT_W-1:0]      pattern_vis;

  prom_seq_timer #(
    .PRESCALE_W(PRESCALE_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (state_q == LATCH),
    .en      (state_q == HOLD),
    .prescale(prescale_q),
    .dur     (mem_dout[DUR_MSB:DUR_LSB]),
    .expire  (expire)
  );

  // stop beats start; start from any state restarts the window
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    pattern_d  = pattern_q;
    done_d     = 1'b0;
    first_d    = first_q;
    last_d     = last_q;
    prescale_d = prescale_q;
    loop_d     = loop_q;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      first_d    = first_addr;
      last_d     = last_addr;
      prescale_d = prescale;
      loop_d     = loop_en;
      mem_addr_d = first_addr;
      state_d    = FETCH;
    end else begin
      case (state_q)
        FETCH: state_d = LATCH;
        LATCH: begin
          pattern_d = mem_dout[PAT_W-1:0];
          state_d   = HOLD;
        end
        HOLD: begin
          if (expire) begin
            if (mem_addr_q != last_q) begin
              mem_addr_d = mem_addr_q + ADDR_W'(1);
              state_d    = FETCH;
            end else if (loop_q) begin
              mem_addr_d = first_q;
              state_d    = FETCH;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      pattern_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      first_q    <= '0;
      last_q     <= '0;
      prescale_q <= '0;
      loop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      pattern_q  <= pattern_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      first_q    <= first_d;
      last_q     <= last_d;
      prescale_q <= prescale_d;
      loop_q     <= loop_d;
    end
  end

`ifdef PROM_SEQ_BLANK_EN
  assign pattern_vis = (state_q == IDLE) ? '0 : pattern_q;
`else
  assign pattern_vis = pattern_q;
`endif

  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign bank0    = pattern_vis[7:0];
  assign bank1    = pattern_vis[15:8];
  assign bank2    = pattern_vis[23:16];
  assign bank3    = pattern_vis[31:24];

endmodule

// File: tb/tb_prom_pattern_sequencer.sv
// Directed self-checking bench for prom_pattern_sequencer with a 128x36 PROM model.
// Honours PROM_SEQ_BLANK_EN for the expected idle bank values.
module tb_prom_pattern_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic [6:0]  first_addr;
  logic [6:0]  last_addr;
  logic [23:0] prescale;
  logic [6:0]  mem_addr;
  logic [35:0] mem_dout;
  logic [7:0]  bank0, bank1, bank2, bank3;
  logic        busy;
  logic        done;

  logic [35:0] prom [0:127];
  int          tests_run;
  int          tests_failed;

  prom_pattern_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .first_addr(first_addr),
    .last_addr (last_addr),
    .prescale  (prescale),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .bank0     (bank0),
    .bank1     (bank1),
    .bank2     (bank2),
    .bank3     (bank3),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous-read PROM port A
  always @(posedge clk) mem_dout <= prom[mem_addr];

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // pulse start for one edge, then scramble config to show it is ignored
  task automatic applyStimulus(input logic [6:0] f, input logic [6:0] l,
                               input logic [23:0] p, input logic lp);
    first_addr = f;
    last_addr  = l;
    prescale   = p;
    loop_en    = lp;
    start      = 1'b1;
    stepCycles(1);
    start      = 1'b0;
    first_addr = 7'd99;
    last_addr  = 7'd99;
    prescale   = 24'd7;
    loop_en    = ~lp;
  endtask

  logic [7:0] idle_b1;
  logic [7:0] idle_b0;
  logic       done_seen;
  logic       busy_low_seen;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < 128; i++) begin
      prom[i] = {4'h0, 8'(i + 64), 8'(i + 32), ~8'(i), 8'(i)};
    end
    prom[5] = 36'h1_000000AA;
    prom[6] = 36'h0_0000BB00;

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    first_addr = '0; last_addr = '0; prescale = '0;
    #12;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_banks", {bank3, bank2, bank1, bank0}, 32'd0);
    rst_n = 1'b1;
    stepCycles(1);

    // two-entry window, prescale 3: 8 then 4 hold cycles
    applyStimulus(7'd5, 7'd6, 24'd3, 1'b0);
    checkOutput("t1_addr5", 32'(mem_addr), 32'd5);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    stepCycles(1);
    checkOutput("t1_bank0_pre", 32'(bank0), 32'd0);
    stepCycles(1);
    checkOutput("t1_bank0_aa", 32'(bank0), 32'hAA);
    stepCycles(8);
    checkOutput("t1_addr6", 32'(mem_addr), 32'd6);
    stepCycles(1);
    checkOutput("t1_bank0_kept", 32'(bank0), 32'hAA);
    stepCycles(1);
    checkOutput("t1_bank1_bb", 32'(bank1), 32'hBB);
    checkOutput("t1_bank0_00", 32'(bank0), 32'h00);
    stepCycles(3);
    checkOutput("t1_done_early", 32'(done), 32'd0);
    checkOutput("t1_busy_hold", 32'(busy), 32'd1);
    stepCycles(1);
    checkOutput("t1_done", 32'(done), 32'd1);
    checkOutput("t1_busy_end", 32'(busy), 32'd0);
    stepCycles(1);
    checkOutput("t1_done_once", 32'(done), 32'd0);
`ifdef PROM_SEQ_BLANK_EN
    idle_b1 = 8'h00;
`else
    idle_b1 = 8'hBB;
`endif
    checkOutput("t1_idle_bank1", 32'(bank1), 32'(idle_b1));

    // wrap-around window 126..1, 3-cycle entries
    applyStimulus(7'd126, 7'd1, 24'd0, 1'b0);
    checkOutput("t2_addr126", 32'(mem_addr), 32'd126);
    stepCycles(2);
    checkOutput("t2_bank0_126", 32'(bank0), 32'h7E);
    stepCycles(1);
    checkOutput("t2_addr127", 32'(mem_addr), 32'd127);
    stepCycles(3);
    checkOutput("t2_addr0", 32'(mem_addr), 32'd0);
    stepCycles(3);
    checkOutput("t2_addr1", 32'(mem_addr), 32'd1);
    stepCycles(2);
    checkOutput("t2_bank0_1", 32'(bank0), 32'h01);
    checkOutput("t2_bank1_1", 32'(bank1), 32'hFE);
    stepCycles(1);
    checkOutput("t2_done", 32'(done), 32'd1);

    // single-entry looping window
    applyStimulus(7'd10, 7'd10, 24'd0, 1'b1);
    stepCycles(2);
    checkOutput("t3_bank0_10", 32'(bank0), 32'h0A);
    done_seen = 1'b0;
    busy_low_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      stepCycles(1);
      if (done) done_seen = 1'b1;
      if (!busy) busy_low_seen = 1'b1;
      if (mem_addr != 7'd10) busy_low_seen = 1'b1;
    end
    checkOutput("t3_no_done", 32'(done_seen), 32'd0);
    checkOutput("t3_busy_addr", 32'(busy_low_seen), 32'd0);
    checkOutput("t3_addr10", 32'(mem_addr), 32'd10);

    // restart mid-HOLD, then stop+start together
    applyStimulus(7'd5, 7'd6, 24'd3, 1'b0);
    stepCycles(4);
    applyStimulus(7'd20, 7'd20, 24'd0, 1'b0);
    checkOutput("t4_addr20", 32'(mem_addr), 32'd20);
    checkOutput("t4_busy", 32'(busy), 32'd1);
    checkOutput("t4_no_done", 32'(done), 32'd0);
    stepCycles(2);
    checkOutput("t4_bank0_20", 32'(bank0), 32'h14);
    first_addr = 7'd30;
    start = 1'b1;
    stop  = 1'b1;
    stepCycles(1);
    start = 1'b0;
    stop  = 1'b0;
    checkOutput("t4_stop_busy", 32'(busy), 32'd0);
    checkOutput("t4_stop_addr", 32'(mem_addr), 32'd20);
    checkOutput("t4_stop_done", 32'(done), 32'd0);
    stepCycles(3);
    checkOutput("t4_idle_done", 32'(done), 32'd0);
`ifdef PROM_SEQ_BLANK_EN
    idle_b0 = 8'h00;
`else
    idle_b0 = 8'h14;
`endif
    checkOutput("t4_idle_bank0", 32'(bank0), 32'(idle_b0));

    // asynchronous reset mid-HOLD
    applyStimulus(7'd5, 7'd6, 24'd3, 1'b0);
    stepCycles(4);
    checkOutput("t5_bank0_aa", 32'(bank0), 32'hAA);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_banks", {bank3, bank2, bank1, bank0}, 32'd0);
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    checkOutput("t5_rst_addr", 32'(mem_addr), 32'd0);
    #1;
    rst_n = 1'b1;
    stepCycles(2);
    checkOutput("t5_after_busy", 32'(busy), 32'd0);
    checkOutput("t5_after_addr", 32'(mem_addr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
